// File: rtl/vx_tcu_tfr_acc_f32.sv
// TFR dot-product reduction back-end: aligns lane products and an FP32 addend
// to the largest exponent, sums them, normalizes and rounds to nearest-even in four stages.
module vx_tcu_tfr_acc_f32 #(
  parameter int N        = 2,
  parameter int TCK      = 2 * N,
  parameter int WA       = 28,
  parameter int EXP_W    = 10,
  parameter int EXP_BIAS = 258
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      valid_in,
  input  logic [31:0]               req_id,
  input  logic [TCK-1:0][24:0]      sig_in,
  input  logic [TCK-1:0][EXP_W-1:0] exp_in,
  input  logic [TCK-1:0][2:0]       excep_in,
  input  logic [31:0]               c_val,
  output logic                      valid_out,
  output logic [31:0]               req_id_out,
  output logic [31:0]               result,
  output logic [2:0]                fflags
);
  localparam int NT    = TCK + 1;
  localparam int ACC_W = WA + $clog2(TCK + 1) + 1;
  localparam int LZ_W  = $clog2(ACC_W) + 1;
  localparam int EW    = EXP_W + 3;
  // Biased FP32 exponent is emax + E_OFF - lzc once the MSB index is folded in.
  localparam int E_OFF = 127 - EXP_BIAS - (WA - 2) + (ACC_W - 1);

  function automatic logic [LZ_W-1:0] lzc_f(input logic [ACC_W-1:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = LZ_W'(ACC_W);
    found = 1'b0;
    for (int i = ACC_W - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZ_W'(ACC_W - 1 - i);
        found = 1'b1;
      end else begin
        n     = n;
        found = found;
      end
    end
    return n;
  endfunction

  function automatic logic [2*ACC_W-1:0] csa_f(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                                               input logic [ACC_W-1:0] c);
    logic [ACC_W-1:0] maj;
    maj = (a & b) | (a & c) | (b & c);
    return {a ^ b ^ c, maj[ACC_W-2:0], 1'b0};
  endfunction

  logic [NT-1:0]            t_sign;
  logic [NT-1:0][23:0]      t_mag;
  logic [NT-1:0][EXP_W-1:0] t_exp;
  logic [EXP_W-1:0]         emax;
  logic                     any_nan, pos_inf, neg_inf;

  logic                     s1_valid, s1_nan, s1_inf, s1_isgn;
  logic [31:0]              s1_id;
  logic [NT-1:0]            s1_sign;
  logic [NT-1:0][23:0]      s1_mag;
  logic [NT-1:0][EXP_W-1:0] s1_exp;
  logic [EXP_W-1:0]         s1_emax;

  logic [NT-1:0][EXP_W-1:0] shamt;
  logic [NT-1:0][WA-1:0]    aligned;
  logic [NT-1:0][ACC_W-1:0] term;

  logic                     s2_valid, s2_nan, s2_inf, s2_isgn;
  logic [31:0]              s2_id;
  logic [EXP_W-1:0]         s2_emax;
  logic [NT-1:0][ACC_W-1:0] s2_term;

  logic [ACC_W-1:0]         red_s, red_c, sum;

  logic                     s3_valid, s3_nan, s3_inf, s3_isgn;
  logic [31:0]              s3_id;
  logic [EXP_W-1:0]         s3_emax;
  logic [ACC_W-1:0]         s3_sum;

  logic                     neg, guard, sticky, rnd;
  logic [ACC_W-1:0]         mag, norm;
  logic [LZ_W-1:0]          lzc;
  logic [23:0]              mant;
  logic [24:0]              m25;
  logic [22:0]              frac;
  logic [EW-1:0]            e_fin;
  logic [31:0]              res_d;
  logic [2:0]               flg_d;

  // S1: unpack terms (C converted to product format), max exponent, exception reduction
  always_comb begin
    any_nan = (c_val[30:23] == 8'hFF) && (c_val[22:0] != 23'h0);
    pos_inf = (c_val[30:23] == 8'hFF) && (c_val[22:0] == 23'h0) && !c_val[31];
    neg_inf = (c_val[30:23] == 8'hFF) && (c_val[22:0] == 23'h0) && c_val[31];
    for (int i = 0; i < TCK; i++) begin
      t_sign[i] = sig_in[i][24];
      t_mag[i]  = sig_in[i][23:0];
      t_exp[i]  = exp_in[i];
      any_nan   = any_nan | excep_in[i][2];
      pos_inf   = pos_inf | (excep_in[i][1] & ~excep_in[i][0]);
      neg_inf   = neg_inf | (excep_in[i][1] & excep_in[i][0]);
    end
    t_sign[TCK] = c_val[31];
    if (c_val[30:23] != 8'h00 && c_val[30:23] != 8'hFF) begin
      t_mag[TCK] = {1'b1, c_val[22:0]};
      t_exp[TCK] = EXP_W'(c_val[30:23]) + EXP_W'(130);
    end else begin
      t_mag[TCK] = 24'h0;
      t_exp[TCK] = '0;
    end
    emax = '0;
    for (int i = 0; i < NT; i++) begin
      if (t_mag[i] != 24'h0 && t_exp[i] > emax) emax = t_exp[i];
      else emax = emax;
    end
  end

  // S1 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0; s1_id <= 32'h0; s1_sign <= '0; s1_mag <= '0; s1_exp <= '0;
      s1_emax <= '0; s1_nan <= 1'b0; s1_inf <= 1'b0; s1_isgn <= 1'b0;
    end else if (enable) begin
      s1_valid <= valid_in;
      s1_id    <= req_id;
      s1_sign  <= t_sign;
      s1_mag   <= t_mag;
      s1_exp   <= t_exp;
      s1_emax  <= emax;
      s1_nan   <= any_nan | (pos_inf & neg_inf);
      s1_inf   <= pos_inf | neg_inf;
      s1_isgn  <= neg_inf;
    end
  end

  // S2: align each term to emax (truncating), then negate into two's complement
  always_comb begin
    for (int i = 0; i < NT; i++) begin
      shamt[i] = s1_emax - s1_exp[i];
      if (s1_mag[i] == 24'h0 || shamt[i] >= EXP_W'(WA)) aligned[i] = '0;
      else aligned[i] = {s1_mag[i], {(WA-24){1'b0}}} >> shamt[i];
      if (s1_sign[i]) term[i] = ~{{(ACC_W-WA){1'b0}}, aligned[i]} + ACC_W'(1);
      else term[i] = {{(ACC_W-WA){1'b0}}, aligned[i]};
    end
  end

  // S2 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0; s2_id <= 32'h0; s2_emax <= '0; s2_term <= '0;
      s2_nan <= 1'b0; s2_inf <= 1'b0; s2_isgn <= 1'b0;
    end else if (enable) begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_emax  <= s1_emax;
      s2_term  <= term;
      s2_nan   <= s1_nan;
      s2_inf   <= s1_inf;
      s2_isgn  <= s1_isgn;
    end
  end

  // S3: carry-save reduction of all terms followed by one carry-propagate add
  always_comb begin
    red_s = s2_term[0];
    red_c = s2_term[1];
    for (int i = 2; i < NT; i++) begin
      {red_s, red_c} = csa_f(red_s, red_c, s2_term[i]);
    end
    sum = red_s + red_c;
  end

  // S3 register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0; s3_id <= 32'h0; s3_emax <= '0; s3_sum <= '0;
      s3_nan <= 1'b0; s3_inf <= 1'b0; s3_isgn <= 1'b0;
    end else if (enable) begin
      s3_valid <= s2_valid;
      s3_id    <= s2_id;
      s3_emax  <= s2_emax;
      s3_sum   <= sum;
      s3_nan   <= s2_nan;
      s3_inf   <= s2_inf;
      s3_isgn  <= s2_isgn;
    end
  end

  // S4: normalize, round to nearest-even, then pick the special or normal encoding
  always_comb begin
    neg    = s3_sum[ACC_W-1];
    mag    = neg ? (~s3_sum + ACC_W'(1)) : s3_sum;
    lzc    = lzc_f(mag);
    norm   = mag << lzc;
    mant   = norm[ACC_W-1 -: 24];
    guard  = norm[ACC_W-25];
    sticky = |norm[ACC_W-26:0];
    rnd    = guard & (sticky | mant[0]);
    m25    = {1'b0, mant} + {24'h0, rnd};
    frac   = m25[24] ? m25[23:1] : m25[22:0];
    e_fin  = EW'(s3_emax) + EW'(E_OFF) - EW'(lzc) + {{(EW-1){1'b0}}, m25[24]};
    res_d  = 32'h0;
    flg_d  = 3'b000;
    if (s3_nan) begin
      res_d = 32'h7FC0_0000;
      flg_d = 3'b100;
    end else if (s3_inf) begin
      res_d = {s3_isgn, 31'h7F80_0000};
    end else if (mag == '0) begin
      res_d = 32'h0;
    end else if (!e_fin[EW-1] && e_fin >= EW'(255)) begin
      res_d = {neg, 31'h7F80_0000};
      flg_d = 3'b010;
    end else if (e_fin[EW-1] || e_fin == '0) begin
      res_d = {neg, 31'h0};
      flg_d = 3'b001;
    end else begin
      res_d = {neg, e_fin[7:0], frac};
    end
  end

  // S4 / output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0; req_id_out <= 32'h0; result <= 32'h0; fflags <= 3'b000;
    end else if (enable) begin
      valid_out  <= s3_valid;
      req_id_out <= s3_id;
      result     <= res_d;
      fflags     <= flg_d;
    end
  end

endmodule

// File: tb/tb_vx_tcu_tfr_acc_f32.sv
// Scoreboard bench for vx_tcu_tfr_acc_f32: directed test-plan cases plus random
// traffic checked against an arithmetic reference model.
module tb_vx_tcu_tfr_acc_f32;
  logic             clk, reset, enable, valid_in;
  logic [31:0]      req_id, c_val;
  logic [3:0][24:0] sig_in;
  logic [3:0][9:0]  exp_in;
  logic [3:0][2:0]  excep_in;
  logic             valid_out;
  logic [31:0]      req_id_out, result;
  logic [2:0]       fflags;

  vx_tcu_tfr_acc_f32 dut (
    .clk(clk), .reset(reset), .enable(enable), .valid_in(valid_in), .req_id(req_id),
    .sig_in(sig_in), .exp_in(exp_in), .excep_in(excep_in), .c_val(c_val),
    .valid_out(valid_out), .req_id_out(req_id_out), .result(result), .fflags(fflags)
  );

  typedef struct {
    logic [31:0] id;
    logic [31:0] res;
    logic [2:0]  fl;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_x;
  int          compared = 0, mismatched = 0, cyc = 0;
  logic        en_at_edge = 1'b0;
  logic [31:0] next_id;
  logic [24:0] ls[4];
  logic [9:0]  le[4];
  logic [2:0]  lx[4];
  logic [31:0] lc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) en_at_edge <= enable;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer sum of truncated aligned terms, rounded by remainder.
  function automatic logic [34:0] ref_model();
    longint mg[5];
    int     ex[5];
    bit     sg[5];
    bit     nan_f = 1'b0, pinf = 1'b0, ninf = 1'b0, neg;
    int     emax = 0, d, p, sh, e, ec;
    longint sum = 0, a, q, rem, half;
    for (int i = 0; i < 4; i++) begin
      sg[i] = ls[i][24];
      mg[i] = longint'(ls[i][23:0]);
      ex[i] = int'(le[i]);
      if (lx[i][2]) nan_f = 1'b1;
      if (lx[i][1] && lx[i][0]) ninf = 1'b1;
      if (lx[i][1] && !lx[i][0]) pinf = 1'b1;
    end
    ec = int'(lc[30:23]);
    sg[4] = lc[31];
    mg[4] = 0;
    ex[4] = 0;
    if (ec == 255) begin
      if (lc[22:0] != 23'h0) nan_f = 1'b1;
      else if (lc[31]) ninf = 1'b1;
      else pinf = 1'b1;
    end else if (ec != 0) begin
      mg[4] = 64'd8388608 + longint'(lc[22:0]);
      ex[4] = ec + 130;
    end
    if (nan_f || (pinf && ninf)) return {3'b100, 32'h7FC0_0000};
    if (pinf || ninf) return {3'b000, ninf, 31'h7F80_0000};
    for (int i = 0; i < 5; i++) if (mg[i] != 0 && ex[i] > emax) emax = ex[i];
    for (int i = 0; i < 5; i++) begin
      if (mg[i] != 0) begin
        d = emax - ex[i];
        a = (d >= 28) ? 64'd0 : ((mg[i] * 16) >> d);
        sum = sg[i] ? sum - a : sum + a;
      end
    end
    if (sum == 0) return 35'h0;
    neg = (sum < 0);
    a = neg ? -sum : sum;
    p = 0;
    while ((a >> (p + 1)) != 0) p++;
    if (p > 23) begin
      sh   = p - 23;
      q    = a >> sh;
      rem  = a - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end else begin
      q = a << (23 - p);
    end
    e = emax - 258 + (p - 26) + 127;
    if (e >= 255) return {3'b010, neg, 31'h7F80_0000};
    if (e <= 0) return {3'b001, neg, 31'h0};
    return {3'b000, neg, e[7:0], q[22:0]};
  endfunction

  task automatic clear_lanes();
    for (int i = 0; i < 4; i++) begin
      ls[i] = 25'h0;
      le[i] = 10'd258;
      lx[i] = 3'b000;
    end
    lc = 32'h0;
  endtask

  task automatic rand_stim();
    int          mode, r;
    logic [23:0] m;
    mode = $urandom_range(0, 9);
    for (int i = 0; i < 4; i++) begin
      m = 24'($urandom) >> $urandom_range(0, 8);
      ls[i] = ($urandom_range(0, 7) == 0) ? 25'h0 : {1'($urandom_range(0, 1)), m};
      case (mode)
        0:       le[i] = 10'(380 + $urandom_range(0, 10));
        1:       le[i] = 10'(100 + $urandom_range(0, 30));
        default: le[i] = 10'(240 + $urandom_range(0, 40));
      endcase
      r = $urandom_range(0, 40);
      lx[i] = (r == 0) ? 3'b100 : (r == 1) ? {2'b01, 1'($urandom_range(0, 1))} : 3'b000;
    end
    r = $urandom_range(0, 19);
    case (r)
      0:       lc = 32'h0;
      1:       lc = {1'($urandom_range(0, 1)), 31'h7F80_0000};
      2:       lc = 32'h7FC0_0001;
      3:       lc = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
      4:       lc = {1'($urandom_range(0, 1)), 8'hFE, 23'($urandom)};
      default: lc = {1'($urandom_range(0, 1)), 8'(110 + $urandom_range(0, 30)), 23'($urandom)};
    endcase
    if (mode == 1 && r > 9) lc = 32'h0;
  endtask

  // Drive one request and push its expectation; use_c selects a given constant over the model.
  task automatic issue(input bit use_c, input logic [31:0] c_res, input logic [2:0] c_fl, input int lat);
    exp_t        x;
    logic [34:0] m;
    for (int i = 0; i < 4; i++) begin
      sig_in[i]   = ls[i];
      exp_in[i]   = le[i];
      excep_in[i] = lx[i];
    end
    c_val    = lc;
    req_id   = next_id;
    valid_in = 1'b1;
    m        = ref_model();
    x.id     = next_id;
    x.res    = use_c ? c_res : m[31:0];
    x.fl     = use_c ? c_fl : m[34:32];
    x.cyc    = (lat < 0) ? -1 : cyc + lat;
    sbq.push_back(x);
    next_id  = next_id + 32'd1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: compare every freshly loaded output against the scoreboard head
  always @(negedge clk) begin
    if (!reset && en_at_edge && valid_out) begin
      if (sbq.size() == 0) begin
        check("unexpected_valid_out", req_id_out, 32'hFFFF_FFFF);
      end else begin
        mon_x = sbq.pop_front();
        check("req_id_out", req_id_out, mon_x.id);
        check("result", result, mon_x.res);
        check("fflags", {29'h0, fflags}, {29'h0, mon_x.fl});
        if (mon_x.cyc >= 0) check("latency", cyc, mon_x.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; reset = 1'b0; enable = 1'b1; valid_in = 1'b0; req_id = 32'h0;
    sig_in = '0; exp_in = '0; excep_in = '0; c_val = 32'h0;
    next_id = 32'h0000_1000;
    clear_lanes();
    #2 reset = 1'b1;
    #2;
    check("rst_valid_out", {31'h0, valid_out}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_fflags", {29'h0, fflags}, 32'h0);
    check("rst_req_id_out", req_id_out, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // simple sum, then the same with a 3-cycle stall mid-flight
    for (int i = 0; i < 4; i++) ls[i] = 25'h040_0000;
    issue(1'b1, 32'h4080_0000, 3'b000, 4);
    idle(6);
    issue(1'b1, 32'h4080_0000, 3'b000, 7);
    valid_in = 1'b0;
    enable   = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    idle(8);

    // signed cancellation
    clear_lanes();
    ls[0] = 25'h040_0000; ls[1] = 25'h140_0000; lc = 32'h3F80_0000;
    issue(1'b1, 32'h3F80_0000, 3'b000, 4);
    lc = 32'h0;
    issue(1'b1, 32'h0000_0000, 3'b000, 4);

    // alignment: lane1 shifted fully out
    clear_lanes();
    ls[0] = 25'h040_0000; ls[1] = 25'h040_0000; le[1] = 10'd228; lc = 32'h3F80_0000;
    issue(1'b1, 32'h4000_0000, 3'b000, 4);
    clear_lanes();
    ls[0] = 25'h07F_FFFF; lc = 32'h3F80_0000;
    issue(1'b0, 32'h0, 3'b000, 4);
    // exact ties: odd LSB rounds up with carry-out, even LSB stays
    clear_lanes();
    ls[0] = 25'h0FF_FFFF; ls[1] = 25'h080_0000; le[1] = 10'd234;
    issue(1'b1, 32'h4080_0000, 3'b000, 4);
    ls[0] = 25'h0FF_FFFE;
    issue(1'b1, 32'h407F_FFFE, 3'b000, 4);

    // exceptions
    clear_lanes();
    lx[0] = 3'b010; lx[1] = 3'b011;
    issue(1'b1, 32'h7FC0_0000, 3'b100, 4);
    clear_lanes();
    lx[2] = 3'b100; ls[0] = 25'h040_0000;
    issue(1'b1, 32'h7FC0_0000, 3'b100, 4);
    clear_lanes();
    ls[0] = 25'h040_0000; ls[1] = 25'h140_0000; lc = 32'hFF80_0000;
    issue(1'b1, 32'hFF80_0000, 3'b000, 4);

    // overflow and underflow
    clear_lanes();
    ls[0] = 25'h040_0000; le[0] = 10'd385; lc = 32'h7F7F_FFFF;
    issue(1'b1, 32'h7F80_0000, 3'b010, 4);
    clear_lanes();
    ls[0] = 25'h040_0000; le[0] = 10'd120;
    issue(1'b1, 32'h0000_0000, 3'b001, 4);
    idle(8);

    // reset with one result on the output and three requests in flight
    for (int i = 0; i < 4; i++) begin
      rand_stim();
      issue(1'b0, 32'h0, 3'b000, 4);
    end
    #1 valid_in = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_valid_out", {31'h0, valid_out}, 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_req_id_out", req_id_out, 32'h0);
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(10);

    // back-to-back random requests
    for (int i = 0; i < 8; i++) begin
      rand_stim();
      issue(1'b0, 32'h0, 3'b000, 4);
    end
    idle(6);

    // random traffic with bubbles and stalls
    for (int i = 0; i < 150; i++) begin
      rand_stim();
      issue(1'b0, 32'h0, 3'b000, -1);
      if ($urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        enable   = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        enable = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 2));
      end
    end
    valid_in = 1'b0;

    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vx_tcu_tfr_acc_f32.md
# VX_tcu_tfr_acc_f32

Pipelined reduction back-end of the TCU TFR dot-product datapath. It consumes the per-lane signed product significands, biased product exponents and exception flags that the TFR multiplier front-end emits, plus an FP32 accumulator operand C. It aligns every term to the maximum exponent, sums them in two's complement, normalizes, and rounds to nearest-even. It returns one FP32 result per request with a fixed 4-cycle latency and a global stall enable.

## Interface
- `N`, 2: 32-bit input words per operand; `TCK` = 2*N product lanes.
- `TCK`, 2*N: number of product lanes.
- `WA`, 28: alignment window width in bits; the binary point sits after bit WA-2.
- `EXP_W`, 10: product exponent width.
- `EXP_BIAS`, 258: exponent code meaning 2^0.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  pipeline advance; when 0 all stages hold.
- `valid_in`  in  1  request valid.
- `req_id`  in  32  request tag.
- `sig_in`  in  TCK×25  per lane {sign, mag[23:0]}; value = mag/2^22.
- `exp_in`  in  TCK×EXP_W  per lane; term = ±mag/2^22 · 2^(exp−EXP_BIAS).
- `excep_in`  in  TCK×fedp_excep_t  per lane {is_nan, is_inf, sign}, already lane-masked.
- `c_val`  in  32  FP32 accumulator operand.
- `valid_out`  out  1  result valid.
- `req_id_out`  out  32  tag of the result.
- `result`  out  32  FP32 result.
- `fflags`  out  3  {nv, of, uf}.

## Operation
- **C conversion.** If ec≠0, C becomes sig = {1, frac}, E_c = ec + 130. Denormal C (ec = 0) is treated as zero. Infinity and NaN in C are routed to the exception path.
- **Zero terms.** Any term with mag = 0 is excluded from the max-exponent search.
- **S1.** Compute Emax over the nonzero terms (the TCK lanes and C). Reduce exceptions:
  - any lane NaN, or C NaN → NaN;
  - +inf and −inf both present (from lanes or C) → NaN;
  - otherwise any inf → inf with that sign.
- **S2.** Form each term as {mag, (WA−24)'0} >> (Emax − Ei). Shifts of WA or more yield 0. Bits shifted out are discarded (truncated, no sticky). Negate the term if its sign is set. All terms are sign-extended to ACC_W = WA + $clog2(TCK+1) + 1.
- **S3.** Add the TCK+1 terms: CSA tree followed by a carry-propagate adder. Result S, two's complement, ACC_W bits.
- **S4.** Take the sign and magnitude of S, then use a leading-zero count to find MSB position p.
  - Biased FP32 exponent: e = Emax − EXP_BIAS + (p − (WA−2)) + 127.
  - Keep 24 bits from p downward. Guard is the next bit; sticky is the OR of all lower bits. Round to nearest, ties to even.
  - If rounding carries out of the mantissa, increment e.
- **Result selection, in priority order:**
  - NaN → 0x7FC00000, nv = 1.
  - Inf → {sign, 0x7F800000 pattern}.
  - S = 0 → +0 (0x00000000).
  - e ≥ 255 → ±inf, of = 1.
  - e ≤ 0 → ±0 (flush to zero), uf = 1.
  - Otherwise the normal {sign, e[7:0], frac[22:0]}.
- `req_id` travels with `valid` through every stage unchanged.

## Timing
- Four register stages (S1–S4). With `enable` held at 1, `valid_in` accepted at cycle t produces `valid_out` at t+4.
- Throughput is one request per cycle.
- While `enable` = 0, every stage register, including `valid_out`, `result` and `fflags`, holds its value; no request is lost or duplicated.
- Data registers load only when `enable` = 1. Their valid bit is loaded from the previous stage's valid, so a bubble (`valid_in` = 0) propagates as `valid_out` = 0.
- **Reset** (asynchronous, any cycle, including mid-flight):
  - all stage valid bits clear to 0;
  - `valid_out` = 0, `result` = 0, `fflags` = 0, `req_id_out` = 0;
  - in-flight requests are dropped.
- After reset deasserts, the first `valid_out` occurs no earlier than 4 enabled cycles after the next `valid_in`.
- **Back-to-back** requests with differing Emax must not interfere; each stage's data is independent.

## Test plan
- **Simple sum, with stall.** TCK = 4, all lanes sig 0x400000, exp 258; c_val = 0 → result 0x40800000, fflags 0, `valid_out` exactly 4 cycles later. Repeat with `enable` low for 3 cycles mid-flight → arrival delayed by exactly 3 cycles, value unchanged.
- **Signed cancellation.** Lanes {+1.0, −1.0, 0, 0} (sig 0x400000 / 0x1400000, exp 258); c_val 0x3F800000 → 0x3F800000. Lanes {+1, −1, 0, 0} with c = 0 → 0x00000000.
- **Alignment and truncation.** Lane0 1.0 (exp 258), lane1 sig 0x400000 exp 228; c = 0x3F800000 → 0x40000000 (lane1 fully shifted out). Tie case: lane0 sig 0x7FFFFF exp 258 plus c = 0x3F800000 → round-to-even result checked against a bit-accurate model.
- **Exceptions.**
  - Lane0 inf +, lane1 inf − → 0x7FC00000, nv = 1.
  - Lane2 NaN → 0x7FC00000.
  - c = 0xFF800000 with finite lanes → 0xFF800000, nv = 0.
- **Overflow and underflow.**
  - Lane0 sig 0x400000 exp 385 (2^127), c = 0x7F7FFFFF → 0x7F800000, of = 1.
  - Lane0 sig 0x400000 exp 120 (2^−138), c = 0 → 0x00000000, uf = 1.
- **Reset and back-to-back.** Reset asserted with 3 requests in flight → `valid_out` = 0 immediately, no stale results afterward. Then 8 consecutive random requests with unique `req_id` → results arrive in order with matching `req_id_out`, every value equal to the reference model.
